// File: rtl/record_core_if.sv
// Record path bundle: controller control/status, SDRAM write port and audio-in stream.
// The core connects through the slave modport; the controller/bench side uses master.
interface record_core_if;
    logic        record_start;
    logic [22:0] record_select;
    logic        record_pause;
    logic        record_stop;
    logic        record_done;
    logic [22:0] record_length;
    logic        record_write;
    logic [22:0] record_addr;
    logic [31:0] record_writedata;
    logic        record_sdram_finished;
    logic        record_audio_valid;
    logic [31:0] record_audio_data;
    logic        record_audio_ready;

    modport slave (
        input  record_start, record_select, record_pause, record_stop,
        input  record_sdram_finished, record_audio_valid, record_audio_data,
        output record_done, record_length, record_write, record_addr,
        output record_writedata, record_audio_ready
    );

    modport master (
        output record_start, record_select, record_pause, record_stop,
        output record_sdram_finished, record_audio_valid, record_audio_data,
        input  record_done, record_length, record_write, record_addr,
        input  record_writedata, record_audio_ready
    );
endinterface

// File: rtl/record_core.sv
// record_core: buffers audio-in samples in a small FIFO and writes them to consecutive SDRAM words.
// Optional RECORD_LEN_HDR_EN: samples start at base+1 and the final sample count is written to base.
module record_core #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 2**20
) (
    input  logic         i_clk,
    input  logic         i_rst,
    record_core_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(MAX_WORDS + 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PUSH_MAX = PW'(MAX_WORDS);
    localparam logic [22:0]   LEN_MAX  = 23'(MAX_WORDS);
`ifdef RECORD_LEN_HDR_EN
    localparam logic [22:0]   FIRST_OFF = 23'd1;
`else
    localparam logic [22:0]   FIRST_OFF = 23'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_PAUSE,
        S_FLUSH,
`ifdef RECORD_LEN_HDR_EN
        S_HDR,
`endif
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [22:0]   base_q, wr_off_q, length_q;
    logic [PW-1:0] pushes_q;

    logic fifo_empty, fifo_full, abort, eng_active, eng_write, hdr_write;
    logic ready, push, pop;
    logic        wr_req;
    logic [22:0] wr_addr;
    logic [31:0] wr_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign abort      = (state_q != S_IDLE) && !bus.record_start;
    assign eng_active = (state_q == S_REC) || (state_q == S_PAUSE) || (state_q == S_FLUSH);
    assign eng_write  = eng_active && !fifo_empty;
`ifdef RECORD_LEN_HDR_EN
    assign hdr_write  = (state_q == S_HDR);
`else
    assign hdr_write  = 1'b0;
`endif

    // Capture stops accepting once the take limit is reached, even before FLUSH is entered.
    assign ready = (state_q == S_REC) && !fifo_full && (pushes_q != PUSH_MAX);
    assign push  = ready && bus.record_audio_valid;
    assign pop   = eng_write && bus.record_sdram_finished && !abort;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (eng_write) begin
            wr_req  = 1'b1;
            wr_addr = base_q + wr_off_q;
            wr_data = mem[rd_ptr_q];
        end else if (hdr_write) begin
            wr_req  = 1'b1;
            wr_addr = base_q;
            wr_data = {9'b0, length_q};
        end
    end

    assign bus.record_write       = wr_req;
    assign bus.record_addr        = wr_addr;
    assign bus.record_writedata   = wr_data;
    assign bus.record_audio_ready = ready;
    assign bus.record_done        = (state_q == S_DONE);
    assign bus.record_length      = length_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.record_start) state_d = S_REC;
            S_REC: begin
                if (abort)                                         state_d = S_IDLE;
                else if (bus.record_stop || pushes_q == PUSH_MAX)  state_d = S_FLUSH;
                else if (bus.record_pause)                         state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (abort)                  state_d = S_IDLE;
                else if (bus.record_stop)   state_d = S_FLUSH;
                else if (!bus.record_pause) state_d = S_REC;
            end
            S_FLUSH: begin
                if (abort)           state_d = S_IDLE;
`ifdef RECORD_LEN_HDR_EN
                else if (fifo_empty) state_d = S_HDR;
`else
                else if (fifo_empty) state_d = S_DONE;
`endif
            end
`ifdef RECORD_LEN_HDR_EN
            S_HDR: begin
                if (abort)                           state_d = S_IDLE;
                else if (bus.record_sdram_finished)  state_d = S_DONE;
            end
`endif
            S_DONE:  if (abort) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the sample array has no reset; occupancy lives in count_q, so stale entries are never read.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= bus.record_audio_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            base_q   <= '0;
            wr_off_q <= '0;
            length_q <= '0;
            pushes_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE || abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (!push && pop) count_q <= count_q - 1'b1;
            end

            if (state_q == S_IDLE && bus.record_start) begin
                base_q   <= bus.record_select;
                wr_off_q <= FIRST_OFF;
                length_q <= '0;
                pushes_q <= '0;
            end else begin
                if (push) pushes_q <= pushes_q + 1'b1;
                if (pop) begin
                    wr_off_q <= wr_off_q + 1'b1;
                    if (length_q != LEN_MAX) length_q <= length_q + 1'b1;
                end
            end
        end
    end
endmodule
